// File: rtl/sram_step_model_if.sv
// Request/response bundle between the aqed monitor and the step-level SRAM model.
interface sram_step_model_if;
  logic        clk_en;
  logic        flush;
  logic        wen_in;
  logic        ren_in;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        busy;
  logic        addr_err;

  modport master (
    output clk_en, flush, wen_in, ren_in, addr_in, data_in,
    input  data_out, valid_out, busy, addr_err
  );

  modport slave (
    input  clk_en, flush, wen_in, ren_in, addr_in, data_in,
    output data_out, valid_out, busy, addr_err
  );
endinterface

// File: rtl/sram_step_model.sv
// Single-port word-addressed SRAM model with a flush-driven clear sweep.
// Optional macro READ_BYPASS_EN: same-cycle write+read returns the written data.
module sram_step_model #(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              reset,
  sram_step_model_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   sweep_cnt;
  logic [15:0]     data_out_q;
  logic            valid_q;
  logic            busy_q;
  logic            addr_err_q;

  logic [15:0]     mem [DEPTH];

  logic            in_range;
  logic [AW-1:0]   idx;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [15:0]     mem_wdata;

  // Full 16-bit compare so out-of-range addresses never alias onto the array.
  assign in_range = {1'b0, bus.addr_in} < 17'(DEPTH);
  assign idx      = bus.addr_in[AW-1:0];

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!reset && bus.clk_en) begin
      unique case (state)
        IDLE: begin
          if (!bus.flush && bus.wen_in && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = idx;
            mem_wdata = bus.data_in;
          end
        end
        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = sweep_cnt;
        end
        default: ;
      endcase
    end
  end

  // Array has no reset: a reset mid-sweep leaves uncleared words untouched.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (bus.clk_en) begin
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.flush) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            busy_q    <= 1'b1;
          end else if ((bus.wen_in || bus.ren_in) && !in_range) begin
            addr_err_q <= 1'b1;
          end else if (bus.wen_in && bus.ren_in) begin
`ifdef READ_BYPASS_EN
            data_out_q <= bus.data_in;
            valid_q    <= 1'b1;
`else
            valid_q    <= 1'b0;
`endif
          end else if (bus.ren_in) begin
            data_out_q <= mem[idx];
            valid_q    <= 1'b1;
          end
        end
        CLEAR: begin
          if (bus.flush) begin
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == AW'(DEPTH - 1)) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.addr_err  = addr_err_q;

endmodule
